// File: rtl/line_threat_scanner.sv
// Scans the N x N board one line per cycle: a completed line first, then a winning move, then a block.
// Latency is 1 cycle per line evaluated plus 1 for done; start is ignored until the block is back in IDLE.
module line_threat_scanner #(
  parameter int N  = 3,
  parameter int MW = $clog2(N*N+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2*N*N-1:0] board,
  input  logic             me_sel,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [MW-1:0]    move,
  output logic [1:0]       winner,
  output logic             draw
);
  localparam int L  = 2*N + 2;
  localparam int LW = $clog2(L);

  typedef enum logic [2:0] {IDLE, WIN, ATTACK, DEFEND, DONE} state_t;

  state_t           state;
  logic [LW-1:0]    line_idx;
  logic [2*N*N-1:0] board_q;
  logic             me_q;
  logic             draw_pending;

  logic [1:0]       own_code, opp_code, win_code;
  logic             win_hit, att_hit, def_hit, hit, last_line, board_full;
  logic [MW-1:0]    empty_pos;

  // Cell codes and 1-based positions of every line, ordered rows, cols, diag, anti-diag.
  logic [1:0]       line_cells [L][N];
  logic [MW-1:0]    line_pos   [L][N];

  for (genvar l = 0; l < L; l++) begin : g_line
    for (genvar k = 0; k < N; k++) begin : g_cell
      localparam int CELL = (l < N)   ? l*N + k :
                            (l < 2*N) ? k*N + (l - N) :
                            (l == 2*N) ? k*N + k : k*N + (N - 1 - k);
      assign line_cells[l][k] = board_q[2*CELL +: 2];
      assign line_pos[l][k]   = MW'(CELL + 1);
    end
  end

  assign own_code = me_q ? 2'b01 : 2'b10;
  assign opp_code = me_q ? 2'b10 : 2'b01;

  always_comb begin
    board_full = 1'b1;
    for (int p = 0; p < N*N; p++)
      if (board[2*p +: 2] == 2'b00) board_full = 1'b0;
  end

  // A blocked (11) cell is counted in no category, so no pass can ever match its line.
  always_comb begin
    int n_a, n_b, n_own, n_opp, n_emp;
    n_a = 0; n_b = 0; n_own = 0; n_opp = 0; n_emp = 0;
    empty_pos = '0;
    for (int k = 0; k < N; k++) begin
      if (line_cells[line_idx][k] == 2'b10) n_a++;
      if (line_cells[line_idx][k] == 2'b01) n_b++;
      if (line_cells[line_idx][k] == own_code) n_own++;
      if (line_cells[line_idx][k] == opp_code) n_opp++;
      if (line_cells[line_idx][k] == 2'b00) begin
        n_emp++;
        empty_pos = line_pos[line_idx][k];
      end
    end
    win_hit  = (n_a == N) || (n_b == N);
    win_code = (n_a == N) ? 2'b10 : 2'b01;
    att_hit  = (n_own == N - 1) && (n_emp == 1);
    def_hit  = (n_opp == N - 1) && (n_emp == 1);
  end

  assign hit = (state == WIN && win_hit) || (state == ATTACK && att_hit) ||
               (state == DEFEND && def_hit);
  assign last_line = (line_idx == LW'(L - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      line_idx     <= '0;
      board_q      <= '0;
      me_q         <= 1'b0;
      draw_pending <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      move         <= '0;
      winner       <= 2'b00;
      draw         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          board_q      <= board;
          me_q         <= me_sel;
          draw_pending <= board_full;
          line_idx     <= '0;
          state        <= WIN;
          busy         <= 1'b1;
          found        <= 1'b0;
          move         <= '0;
          winner       <= 2'b00;
          draw         <= 1'b0;
        end
        WIN, ATTACK, DEFEND: begin
          if (hit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (state == WIN) winner <= win_code;
            else begin
              found <= 1'b1;
              move  <= empty_pos;
            end
          end else if (last_line) begin
            line_idx <= '0;
            if (state == WIN) state <= ATTACK;
            else if (state == ATTACK) state <= DEFEND;
            else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              draw  <= draw_pending;
            end
          end else begin
            line_idx <= line_idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_threat_scanner.sv
// Bench for line_threat_scanner: directed scenarios with hand-derived results plus random boards
// checked against a line-by-line reference model, on an N=3 and an N=4 instance.
module tb_line_threat_scanner;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start3, me3, busy3, done3, found3, draw3;
  logic [17:0] board3;
  logic [3:0]  move3;
  logic [1:0]  winner3;
  logic        start4, me4, busy4, done4, found4, draw4;
  logic [31:0] board4;
  logic [4:0]  move4;
  logic [1:0]  winner4;

  line_threat_scanner #(.N(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .board(board3), .me_sel(me3),
    .busy(busy3), .done(done3), .found(found3), .move(move3), .winner(winner3), .draw(draw3));
  line_threat_scanner #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .board(board4), .me_sel(me4),
    .busy(busy4), .done(done4), .found(found4), .move(move4), .winner(winner4), .draw(draw4));

  int n_cmp = 0;
  int n_err = 0;
  int sel = 3;

  logic       o_busy, o_done, o_found, o_draw;
  logic [4:0] o_move;
  logic [1:0] o_winner;
  always_comb begin
    o_busy   = (sel == 3) ? busy3   : busy4;
    o_done   = (sel == 3) ? done3   : done4;
    o_found  = (sel == 3) ? found3  : found4;
    o_draw   = (sel == 3) ? draw3   : draw4;
    o_move   = (sel == 3) ? {1'b0, move3} : move4;
    o_winner = (sel == 3) ? winner3 : winner4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] setp(input logic [127:0] b, input int p, input logic [1:0] c);
    int sh;
    sh = 2*p - 2;
    return (b & ~(128'(3) << sh)) | (128'(c) << sh);
  endfunction

  function automatic logic [1:0] getp(input logic [127:0] b, input int p);
    logic [127:0] t;
    t = b >> (2*p - 2);
    return t[1:0];
  endfunction

  // Reference: walk the passes and lines in priority order straight from the game rules.
  function automatic void ref_scan(input int n, input logic [127:0] b, input logic ms,
      output logic f, output int mv, output logic [1:0] w, output logic d, output int lat);
    int nl, na, nb, no, np, ne, ep, p;
    logic [1:0] own, opp, c;
    nl = 2*n + 2;
    own = ms ? 2'b01 : 2'b10;
    opp = ms ? 2'b10 : 2'b01;
    f = 1'b0; mv = 0; w = 2'b00; lat = 3*nl + 1;
    d = 1'b1;
    for (int q = 1; q <= n*n; q++) if (getp(b, q) == 2'b00) d = 1'b0;
    for (int pass = 0; pass < 3; pass++) begin
      for (int l = 0; l < nl; l++) begin
        na = 0; nb = 0; no = 0; np = 0; ne = 0; ep = 0;
        for (int k = 0; k < n; k++) begin
          p = (l < n) ? l*n + k + 1 : (l < 2*n) ? k*n + (l - n) + 1 :
              (l == 2*n) ? k*n + k + 1 : k*n + (n - 1 - k) + 1;
          c = getp(b, p);
          if (c == 2'b10) na++;
          if (c == 2'b01) nb++;
          if (c == own) no++;
          if (c == opp) np++;
          if (c == 2'b00) begin ne++; ep = p; end
        end
        if (pass == 0 && (na == n || nb == n)) begin
          w = (na == n) ? 2'b10 : 2'b01; d = 1'b0; lat = l + 2; return;
        end
        if ((pass == 1 && no == n - 1 && ne == 1) || (pass == 2 && np == n - 1 && ne == 1)) begin
          f = 1'b1; mv = ep; d = 1'b0; lat = pass*nl + l + 2; return;
        end
      end
    end
  endfunction

  task automatic drive(input int n, input logic [127:0] b, input logic ms, input logic st);
    if (n == 3) begin board3 = b[17:0]; me3 = ms; start3 = st; end
    else begin board4 = b[31:0]; me4 = ms; start4 = st; end
  endtask

  task automatic run_scan(input string tag, input int n, input logic [127:0] b, input logic ms,
      input logic ef, input int emv, input logic [1:0] ew, input logic ed, input int elat);
    int cyc;
    sel = n;
    @(negedge clk); drive(n, b, ms, 1'b1);
    @(posedge clk);
    @(negedge clk); drive(n, ~b, ~ms, 1'b0);
    cyc = 1;
    check({tag, "_busy1"}, 32'(o_busy), 1);
    check({tag, "_clr"}, {o_found, o_move, o_winner, o_draw, o_done}, 0);
    while (!o_done && cyc < 200) begin @(negedge clk); cyc++; end
    check({tag, "_lat"}, cyc, elat);
    check({tag, "_found"}, 32'(o_found), 32'(ef));
    check({tag, "_move"}, 32'(o_move), emv);
    check({tag, "_winner"}, 32'(o_winner), 32'(ew));
    check({tag, "_draw"}, 32'(o_draw), 32'(ed));
    check({tag, "_busy0"}, 32'(o_busy), 0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(o_done), 0);
    check({tag, "_hold"}, {o_found, o_move, o_winner, o_draw}, {ef, 5'(emv), ew, ed});
  endtask

  task automatic run_model(input string tag, input int n, input logic [127:0] b, input logic ms);
    logic f, d;
    int mv, lat;
    logic [1:0] w;
    ref_scan(n, b, ms, f, mv, w, d, lat);
    run_scan(tag, n, b, ms, f, mv, w, d, lat);
  endtask

  initial begin
    logic [127:0] b;
    int cyc, r;
    logic seen;
    reset = 1'b1;
    start3 = 1'b0; me3 = 1'b0; board3 = '0;
    start4 = 1'b0; me4 = 1'b0; board4 = '0;
    repeat (2) @(negedge clk);
    check("reset3", {busy3, done3, found3, move3, winner3, draw3}, 0);
    check("reset4", {busy4, done4, found4, move4, winner4, draw4}, 0);
    reset = 1'b0;

    b = setp(setp('0, 1, 2'b10), 2, 2'b10);
    run_scan("attack_row0", 3, b, 1'b0, 1'b1, 3, 2'b00, 1'b0, 10);

    b = setp(setp(setp(setp('0, 1, 2'b01), 5, 2'b01), 2, 2'b10), 4, 2'b10);
    run_scan("defend_diag", 3, b, 1'b0, 1'b1, 9, 2'b00, 1'b0, 24);

    b = setp(setp(setp(setp('0, 7, 2'b10), 8, 2'b10), 1, 2'b01), 2, 2'b01);
    run_scan("prio_me0", 3, b, 1'b0, 1'b1, 9, 2'b00, 1'b0, 12);
    run_scan("prio_me1", 3, b, 1'b1, 1'b1, 3, 2'b00, 1'b0, 10);

    b = setp(setp(setp('0, 1, 2'b01), 5, 2'b01), 9, 2'b01);
    run_scan("win_diag", 3, b, 1'b0, 1'b0, 0, 2'b01, 1'b0, 8);

    b = setp(setp(setp(setp(setp('0, 4, 2'b10), 6, 2'b10), 2, 2'b01), 8, 2'b01), 5, 2'b11);
    run_scan("blocked5", 3, b, 1'b0, 1'b0, 0, 2'b00, 1'b0, 25);

    b = '0;
    b = setp(b, 1, 2'b10); b = setp(b, 2, 2'b01); b = setp(b, 3, 2'b10);
    b = setp(b, 4, 2'b10); b = setp(b, 5, 2'b01); b = setp(b, 6, 2'b01);
    b = setp(b, 7, 2'b01); b = setp(b, 8, 2'b10); b = setp(b, 9, 2'b10);
    run_scan("draw3", 3, b, 1'b0, 1'b0, 0, 2'b00, 1'b1, 25);

    b = '0;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        b = setp(b, rr*4 + cc + 1, (((rr/2) + cc) % 2 == 0) ? 2'b10 : 2'b01);
    run_scan("draw4", 4, b, 1'b0, 1'b0, 0, 2'b00, 1'b1, 31);

    // start held high across a whole scan and into the following IDLE cycle
    sel = 3;
    b = setp(setp('0, 1, 2'b10), 2, 2'b10);
    @(negedge clk); drive(3, b, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk); cyc = 1;
    while (!o_done && cyc < 200) begin @(negedge clk); cyc++; end
    check("hold_lat", cyc, 10);
    check("hold_move", 32'(o_move), 3);
    @(negedge clk);
    check("hold_idle", {o_busy, o_done, o_found}, 3'b001);
    @(negedge clk);
    check("hold_restart", {o_busy, o_found}, 2'b10);
    start3 = 1'b0;
    cyc = 0;
    while (!o_done && cyc < 200) begin @(negedge clk); cyc++; end
    check("hold_drain", 32'(o_done), 1);
    @(negedge clk);

    // reset during a scan
    @(negedge clk); drive(3, '0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk); start3 = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_busy_before", 32'(o_busy), 1);
    reset = 1'b1;
    #1;
    check("rst_async", {o_busy, o_done, o_found, o_move, o_winner, o_draw}, 0);
    seen = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) begin @(negedge clk); if (o_done || o_busy) seen = 1'b1; end
    check("rst_no_resume", 32'(seen), 0);
    b = setp(setp('0, 1, 2'b10), 2, 2'b10);
    run_scan("rst_rescan", 3, b, 1'b0, 1'b1, 3, 2'b00, 1'b0, 10);

    for (int t = 0; t < 40; t++) begin
      b = '0;
      for (int p = 1; p <= 9; p++) begin
        r = $urandom_range(0, 9);
        b = setp(b, p, (r < 3) ? 2'b00 : (r < 6) ? 2'b10 : (r < 9) ? 2'b01 : 2'b11);
      end
      run_model("rand3", 3, b, 1'($urandom_range(0, 1)));
    end
    for (int t = 0; t < 10; t++) begin
      b = '0;
      for (int p = 1; p <= 16; p++) begin
        r = $urandom_range(0, 9);
        b = setp(b, p, (r < 2) ? 2'b00 : (r < 5) ? 2'b10 : (r < 9) ? 2'b01 : 2'b11);
      end
      run_model("rand4", 4, b, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/line_threat_scanner.md
Name: line_threat_scanner

Overview:
- Parametrised, sequential successor to the 3x3 single-cycle win/block checker. Handles an N x N board and scans one line per clock.
- Reports three things: a completed line (winner), a winning move for the machine player, or a blocking move against the opponent. The board full / draw condition is also flagged.
- Sits between the board-state registers and the CPU-move FSM; the caller uses a start/done handshake.

Parameters:
- N, 3, board side length; legal range 3..8. Line count L = 2N+2, ordered rows 0..N-1, cols 0..N-1, main diagonal, anti-diagonal.
- MW, $clog2(N*N+1), move index width; 4 for N=3.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  request scan; accepted only in IDLE
- board  in  2*N*N  cell codes, row-major. Position p (1..N*N) occupies bits [2p-1:2p-2]. Codes: 00 empty, 10 player A, 01 player B, 11 blocked.
- me_sel  in  1  0: own=10, opp=01; 1: own=01, opp=10; sampled with start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse, result valid
- found  out  1  move produced
- move  out  MW  1-based position to play; 0 when found=0
- winner  out  2  code of a completed line, 00 if none
- draw  out  1  no empty cell and no winner

Behaviour:
- Reset: state=IDLE. busy, done, found, move, winner, draw are all 0. Reset mid-scan aborts immediately; the next scan requires a fresh start.
- start in IDLE: latch board and me_sel; draw_pending = (no 00 cell). Enter WIN with line_idx=0.
- start while busy or in DONE is ignored. The latched board is unaffected by later board changes.
- Each scan cycle evaluates latched line line_idx. It counts own, opp and empty cells and records the index of the empty cell. A 11 cell is neither empty nor owned, so that line can never match.
- WIN pass: a hit is all N cells equal to 10, or all equal to 01. On hit, winner=that code and found=0.
- ATTACK pass: a hit is own count == N-1 and empty == 1. On hit, found=1 and move=the empty position.
- DEFEND pass: a hit is opp count == N-1 and empty == 1. Same outputs as ATTACK.
- Pass sequencing:
  - Hit at line j: result registers are captured at the end of that cycle, the next state is DONE, and the remaining lines and passes are skipped.
  - No hit at line L-1: move to the next pass (WIN -> ATTACK -> DEFEND -> DONE), with line_idx reset to 0.
- Priority: WIN over ATTACK over DEFEND; within a pass, the lowest line_idx wins. The empty cell in a hit line is unique, so there is no tie inside a line.
- DONE: done=1 for exactly one cycle, busy=0, draw = draw_pending & (winner==00). Then return to IDLE.
- Result outputs hold until the next accepted start, which clears them to 0 in the same edge.
- Latency (start sampled at edge 0): line i of pass p (p=0,1,2) is evaluated in cycle p*L+i+1. done is high in the cycle after the hit. With no hit, done is high in cycle 3L+1 (25 for N=3).
- Result fields are mutually exclusive: found=1 implies winner=00 and draw=0.
- A new start is accepted in the IDLE cycle immediately after DONE.

Test Plan:
- N=3, me_sel=0. Positions 1,2 = 10, rest 00 -> ATTACK line 0 in cycle 9. done in cycle 10: found=1, move=3, winner=00.
- Positions 1,5 = 01; 2,4 = 10; rest 00 -> ATTACK finds nothing; DEFEND main diagonal (idx 6) in cycle 23. done in cycle 24: found=1, move=9.
- Positions 7,8 = 10; 1,2 = 01; rest 00 -> attack priority: done in cycle 12, move=9 (row 2 hit, not the block at 3). Same board with me_sel=1 -> move=3, done in cycle 10.
- Positions 1,5,9 = 01 -> WIN main diagonal, done in cycle 8: winner=01, found=0, move=0. Also check that a 11 at position 5 suppresses every line through 5.
- Full draw board 10,01,10 / 10,01,01 / 01,10,10 -> done in cycle 25: draw=1, found=0, winner=00. Repeat with N=4 parameter and the analogous full draw board -> done in cycle 31.
- Hold start high through a scan: no restart until IDLE. Assert reset in cycle 5: all outputs 0 asynchronously, no done pulse, and the next start rescans from line 0.
